// File: rtl/dense_argmax.sv
// Streaming argmax over CLASS_COUNT signed scores; reports index/value of the largest.
// Optional DENSE_ARGMAX_MARGIN_EN builds a second-best tracker and drives margin.
module dense_argmax #(
  parameter int CLASS_COUNT = 10,
  parameter int DATA_SIZE   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           valid,
  input  logic [DATA_SIZE-1:0]           dataIn,
  output logic                           ready,
  output logic                           busy,
  output logic                           done,
  output logic                           resultValid,
  output logic [$clog2(CLASS_COUNT)-1:0] classIdx,
  output logic [DATA_SIZE-1:0]           maxValue,
  output logic [DATA_SIZE:0]             margin
);

  localparam int IDX_W = $clog2(CLASS_COUNT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CLASS_COUNT - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t                       state, stateNext;
  logic   [IDX_W-1:0]           counter, counterNext;
  logic   [IDX_W-1:0]           bestIdx, bestIdxNext;
  logic signed [DATA_SIZE-1:0]  best, bestNext;
  logic                         accept, firstBeat, lastBeat, isGreater;

  assign ready     = (state != DONE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE) && !clear;
  assign accept    = valid && ready;
  assign isGreater = $signed(dataIn) > best;
  assign firstBeat = (state == IDLE) && accept && !clear;
  assign lastBeat  = (state == COLLECT) && accept && !clear && (counter == LAST_IDX);

  always_comb begin
    stateNext   = state;
    counterNext = counter;
    bestNext    = best;
    bestIdxNext = bestIdx;
    case (state)
      IDLE: begin
        if (accept) begin
          bestNext    = $signed(dataIn);
          bestIdxNext = '0;
          counterNext = IDX_W'(1);
          stateNext   = COLLECT;
        end
      end
      COLLECT: begin
        if (accept) begin
          // strict compare keeps the lowest index on ties
          if (isGreater) begin
            bestNext    = $signed(dataIn);
            bestIdxNext = counter;
          end
          counterNext = counter + IDX_W'(1);
          if (counter == LAST_IDX) stateNext = DONE;
        end
      end
      DONE: begin
        counterNext = '0;
        stateNext   = IDLE;
      end
      default: begin
        counterNext = '0;
        stateNext   = IDLE;
      end
    endcase
    if (clear) begin
      stateNext   = IDLE;
      counterNext = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      counter <= '0;
      best    <= '0;
      bestIdx <= '0;
    end else begin
      state   <= stateNext;
      counter <= counterNext;
      best    <= bestNext;
      bestIdx <= bestIdxNext;
    end
  end

  // Result is captured from the next-state values on the last accept so it is
  // already visible in the DONE cycle alongside the done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resultValid <= 1'b0;
      classIdx    <= '0;
      maxValue    <= '0;
    end else if (clear) begin
      resultValid <= 1'b0;
      classIdx    <= '0;
      maxValue    <= '0;
    end else if (firstBeat) begin
      resultValid <= 1'b0;
    end else if (lastBeat) begin
      resultValid <= 1'b1;
      classIdx    <= bestIdxNext;
      maxValue    <= bestNext;
    end
  end

`ifdef DENSE_ARGMAX_MARGIN_EN
  localparam logic signed [DATA_SIZE-1:0] MOST_NEG = {1'b1, {(DATA_SIZE-1){1'b0}}};

  logic signed [DATA_SIZE-1:0] second, secondNext;
  logic        [DATA_SIZE:0]   marginNext;

  always_comb begin
    secondNext = second;
    if (state == IDLE && accept) begin
      secondNext = MOST_NEG;
    end else if (state == COLLECT && accept) begin
      if (isGreater) secondNext = best;
      else if ($signed(dataIn) > second) secondNext = $signed(dataIn);
    end
    marginNext = {bestNext[DATA_SIZE-1], bestNext} - {secondNext[DATA_SIZE-1], secondNext};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      second <= '0;
      margin <= '0;
    end else begin
      second <= secondNext;
      if (clear) margin <= '0;
      else if (lastBeat) margin <= marginNext;
    end
  end
`else
  assign margin = '0;
`endif

endmodule

// File: tb/tb_dense_argmax.sv
// Directed bench for dense_argmax: frames, ties, extremes, gaps, clear and mid-frame reset.
module tb_dense_argmax;

  localparam int CC = 10;
  localparam int DS = 16;

  logic          clk, rst, clear, valid;
  logic [DS-1:0] dataIn;
  logic          ready, busy, done, resultValid;
  logic [3:0]    classIdx;
  logic [DS-1:0] maxValue;
  logic [DS:0]   margin;

  int checks = 0;
  int errors = 0;

  dense_argmax #(.CLASS_COUNT(CC), .DATA_SIZE(DS)) dut (
    .clk(clk), .rst(rst), .clear(clear), .valid(valid), .dataIn(dataIn),
    .ready(ready), .busy(busy), .done(done), .resultValid(resultValid),
    .classIdx(classIdx), .maxValue(maxValue), .margin(margin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input bit ok, input longint obs, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [DS:0] expMargin(input logic [DS:0] m);
`ifdef DENSE_ARGMAX_MARGIN_EN
    return m;
`else
    return '0;
`endif
  endfunction

  task automatic runFrame(input string name, input logic [DS-1:0] s [CC], input bit gaps,
                          input logic [3:0] eIdx, input logic [DS-1:0] eMax, input logic [DS:0] eMar);
    logic [DS:0] em;
    em = expMargin(eMar);
    for (int unsigned i = 0; i < CC; i++) begin
      if (gaps) begin
        valid = 1'b0;
        @(negedge clk);
        chk({name, "_gapBusy"}, busy === (i > 0), busy, (i > 0));
        chk({name, "_gapDone"}, done === 1'b0, done, 0);
      end
      chk({name, "_ready"}, ready === 1'b1, ready, 1);
      chk({name, "_busy"}, busy === (i > 0), busy, (i > 0));
      chk({name, "_noDone"}, done === 1'b0, done, 0);
      if (i == 1) chk({name, "_rvDrop"}, resultValid === 1'b0, resultValid, 0);
      valid  = 1'b1;
      dataIn = s[i];
      @(negedge clk);
    end
    valid = 1'b0;
    chk({name, "_done"}, done === 1'b1, done, 1);
    chk({name, "_doneReady"}, ready === 1'b0, ready, 0);
    chk({name, "_doneBusy"}, busy === 1'b1, busy, 1);
    chk({name, "_rv"}, resultValid === 1'b1, resultValid, 1);
    chk({name, "_idx"}, classIdx === eIdx, classIdx, eIdx);
    chk({name, "_max"}, maxValue === eMax, maxValue, eMax);
    chk({name, "_margin"}, margin === em, margin, em);
    @(negedge clk);
    chk({name, "_doneLow"}, done === 1'b0, done, 0);
    chk({name, "_readyBack"}, ready === 1'b1, ready, 1);
    chk({name, "_idleBusy"}, busy === 1'b0, busy, 0);
    chk({name, "_rvHold"}, resultValid === 1'b1, resultValid, 1);
    chk({name, "_idxHold"}, classIdx === eIdx, classIdx, eIdx);
    chk({name, "_maxHold"}, maxValue === eMax, maxValue, eMax);
  endtask

  logic [DS-1:0] f [CC];

  initial begin
    rst = 1'b0; clear = 1'b0; valid = 1'b0; dataIn = '0;
    #1;
    chk("rst_ready", ready === 1'b1, ready, 1);
    chk("rst_busy", busy === 1'b0, busy, 0);
    chk("rst_done", done === 1'b0, done, 0);
    chk("rst_rv", resultValid === 1'b0, resultValid, 0);
    chk("rst_idx", classIdx === 4'd0, classIdx, 0);
    chk("rst_max", maxValue === 16'd0, maxValue, 0);
    chk("rst_margin", margin === 17'd0, margin, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    f = '{16'd3, -16'sd7, 16'd12, 16'd5, 16'd12, 16'd0, -16'sd1, 16'd9, 16'd2, 16'd4};
    runFrame("t1", f, 1'b0, 4'd2, 16'd12, 17'd0);

    f = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
          16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
    runFrame("t2", f, 1'b0, 4'd0, 16'h8000, 17'd0);

    f = '{-16'sd5, -16'sd4, -16'sd3, -16'sd2, -16'sd1, 16'd0, 16'd1, 16'd2, 16'd3, 16'd100};
    runFrame("t3", f, 1'b1, 4'd9, 16'd100, 17'd97);

    for (int unsigned i = 0; i < 6; i++) begin
      valid = 1'b1; dataIn = 16'd77;
      @(negedge clk);
    end
    chk("t4_busyBefore", busy === 1'b1, busy, 1);
    clear = 1'b1; valid = 1'b1; dataIn = 16'd999;
    @(negedge clk);
    clear = 1'b0; valid = 1'b0;
    chk("t4_clrBusy", busy === 1'b0, busy, 0);
    chk("t4_clrDone", done === 1'b0, done, 0);
    chk("t4_clrRv", resultValid === 1'b0, resultValid, 0);
    chk("t4_clrIdx", classIdx === 4'd0, classIdx, 0);
    chk("t4_clrMax", maxValue === 16'd0, maxValue, 0);
    chk("t4_clrReady", ready === 1'b1, ready, 1);
    f = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd50, 16'd1};
    runFrame("t4", f, 1'b0, 4'd8, 16'd50, 17'd49);

    for (int unsigned i = 0; i < 4; i++) begin
      valid = 1'b1; dataIn = 16'd200;
      @(negedge clk);
    end
    #2 rst = 1'b0;
    #1;
    chk("t5_rstBusy", busy === 1'b0, busy, 0);
    chk("t5_rstReady", ready === 1'b1, ready, 1);
    chk("t5_rstRv", resultValid === 1'b0, resultValid, 0);
    chk("t5_rstIdx", classIdx === 4'd0, classIdx, 0);
    chk("t5_rstMax", maxValue === 16'd0, maxValue, 0);
    chk("t5_rstMargin", margin === 17'd0, margin, 0);
    valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    f = '{16'd7, -16'sd2, 16'd0, 16'd7, -16'sd9, 16'd3, 16'd20, 16'd8, -16'sd1, 16'd6};
    runFrame("t5", f, 1'b0, 4'd6, 16'd20, 17'd12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
